// File: rtl/plot_arb_pkg.sv
// plot_arb_pkg: shared widths, FSM state encoding and a constant clog2 helper
// for the framebuffer write-port arbiter.
package plot_arb_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int X_W_DEF       = 8;
    localparam int Y_W_DEF       = 7;
    localparam int COL_W_DEF     = 3;
    localparam int MAX_BURST_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWN     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // ceil(log2(value)); used for pointer and burst counter widths
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/plot_arbiter_chk.sv
// plot_arbiter_chk: simulation checker for the arbiter grant vector.
module plot_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input logic               i_clock,
    input logic               i_reset,
    input logic [NUM_REQ-1:0] i_grant
);

    // grant must never name more than one owner
    a_grant_onehot0: assert property (@(posedge i_clock) disable iff (!i_reset) $onehot0(i_grant));

endmodule

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector. Returns a one-hot pick of
// the first requesting index at or after i_rr_ptr, wrapping at NUM_REQ-1.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic               o_valid
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;

    // scan from the highest offset down so the closest requester to the pointer wins
    always_comb begin
        o_pick  = '0;
        o_valid = |i_req;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_rr_ptr} + (PTR_W + 1)'(i);
            if (w_sum >= (PTR_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W + 1)'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (i_req[w_idx]) begin
                o_pick        = '0;
                o_pick[w_idx] = 1'b1;
            end else begin
                o_pick = o_pick;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the vga_adapter write port between NUM_REQ pixel
// producers using round-robin arbitration with burst ownership.
// Optional macro PLOT_ARB_PRIORITY_EN: requester 0 (eraser) wins every idle
// arbitration and does not advance the round-robin pointer.
module plot_arbiter
    import plot_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int X_W       = X_W_DEF,
    parameter int Y_W       = Y_W_DEF,
    parameter int COL_W     = COL_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       last,
    input  logic [NUM_REQ*X_W-1:0]   x_in,
    input  logic [NUM_REQ*Y_W-1:0]   y_in,
    input  logic [NUM_REQ*COL_W-1:0] colour_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic [X_W-1:0]           x_out,
    output logic [Y_W-1:0]           y_out,
    output logic [COL_W-1:0]         colour_out,
    output logic                     plot_out,
    output logic                     busy
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_BURST + 1);

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic               r_stall, w_stall_nxt;
    logic [X_W-1:0]     r_x_out;
    logic [Y_W-1:0]     r_y_out;
    logic [COL_W-1:0]   r_col_out;
    logic               r_plot;

    logic [NUM_REQ-1:0] w_pick, w_sel, w_ack;
    logic               w_valid, w_owner_req, w_last_any, w_hit_max, w_release, w_skip_ptr;
    logic [PTR_W-1:0]   w_owner_idx, w_ptr_after;
    logic [X_W-1:0]     w_x_sel;
    logic [Y_W-1:0]     w_y_sel;
    logic [COL_W-1:0]   w_col_sel;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_pick   (w_pick),
        .o_valid  (w_valid)
    );

`ifdef PLOT_ARB_PRIORITY_EN
    assign w_sel      = req[0] ? NUM_REQ'(1) : w_pick;
    assign w_skip_ptr = r_grant[0];
`else
    assign w_sel      = w_pick;
    assign w_skip_ptr = 1'b0;
`endif

    // grant is only non-zero in S_OWN, so ack is naturally limited to ownership
    assign w_ack       = r_grant & req;
    assign w_owner_req = |w_ack;
    assign w_last_any  = |(w_ack & last);
    assign w_hit_max   = w_owner_req && (r_count == CNT_W'(MAX_BURST - 1));
    assign w_release   = (w_owner_req && (w_last_any || w_hit_max)) || (!w_owner_req && r_stall);
    assign w_ptr_after = (w_owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_owner_idx + PTR_W'(1);

    // and-or mux of the owner's pixel slices and its index
    always_comb begin
        w_owner_idx = '0;
        w_x_sel     = '0;
        w_y_sel     = '0;
        w_col_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_owner_idx = w_owner_idx | (r_grant[i] ? PTR_W'(i) : '0);
            w_x_sel     = w_x_sel   | ({X_W{r_grant[i]}}   & x_in[i*X_W +: X_W]);
            w_y_sel     = w_y_sel   | ({Y_W{r_grant[i]}}   & y_in[i*Y_W +: Y_W]);
            w_col_sel   = w_col_sel | ({COL_W{r_grant[i]}} & colour_in[i*COL_W +: COL_W]);
        end
    end

    // next-state logic: arbitrate in idle, count/stall/release in own, one dead cycle after
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_count_nxt  = r_count;
        w_stall_nxt  = r_stall;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = w_sel;
                    w_count_nxt = '0;
                    w_stall_nxt = 1'b0;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            S_OWN: begin
                if (w_release) begin
                    w_state_nxt  = S_RELEASE;
                    w_grant_nxt  = '0;
                    w_count_nxt  = '0;
                    w_stall_nxt  = 1'b0;
                    w_rr_ptr_nxt = w_skip_ptr ? r_rr_ptr : w_ptr_after;
                end else if (w_owner_req) begin
                    w_count_nxt = r_count + CNT_W'(1);
                    w_stall_nxt = 1'b0;
                end else begin
                    w_stall_nxt = 1'b1;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // state and arbitration registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_count  <= w_count_nxt;
            r_stall  <= w_stall_nxt;
        end
    end

    // pixel output registers: capture the acked pixel, write one cycle later
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_x_out   <= '0;
            r_y_out   <= '0;
            r_col_out <= '0;
            r_plot    <= 1'b0;
        end else begin
            r_plot <= w_owner_req;
            if (w_owner_req) begin
                r_x_out   <= w_x_sel;
                r_y_out   <= w_y_sel;
                r_col_out <= w_col_sel;
            end
        end
    end

    assign grant      = r_grant;
    assign ack        = w_ack;
    assign x_out      = r_x_out;
    assign y_out      = r_y_out;
    assign colour_out = r_col_out;
    assign plot_out   = r_plot;
    assign busy       = (r_state != S_IDLE);

    plot_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .i_clock (clock),
        .i_reset (reset),
        .i_grant (r_grant)
    );

endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: table-driven and sequence checks for plot_arbiter
// (NUM_REQ=4, X_W=8, Y_W=7, COL_W=3, MAX_BURST=16).
module tb_plot_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req   = 4'b0;
    logic [3:0]  last  = 4'b0;
    logic [7:0]  xv [4];
    logic [31:0] x_in;
    logic [27:0] y_in;
    logic [11:0] colour_in;
    logic [3:0]  grant, ack;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot_out, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic [7:0] x;
        logic [3:0] grant;
        logic [3:0] ack;
        logic       plot;
        logic [7:0] xo;
        logic [6:0] yo;
        logic [2:0] co;
        logic       busy;
    } vec_t;

    vec_t tbl [16];

`ifdef PLOT_ARB_PRIORITY_EN
    localparam logic [3:0] EXP_PRI = 4'b0001;
    int rr_order [6]    = '{0, 0, 0, 0, 0, 0};
    int burst_order [6] = '{0, 0, 0, 1, 1, 1};
`else
    localparam logic [3:0] EXP_PRI = 4'b0100;
    int rr_order [6]    = '{0, 1, 3, 0, 1, 3};
    int burst_order [6] = '{0, 1, 0, 1, 0, 1};
`endif
    int burst_len [3] = '{16, 16, 8};

    assign x_in      = {xv[3], xv[2], xv[1], xv[0]};
    assign y_in      = {7'd6, 7'd5, 7'd4, 7'd3};
    assign colour_in = {3'd3, 3'd2, 3'd1, 3'd0};

    plot_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .last       (last),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .grant      (grant),
        .ack        (ack),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot_out   (plot_out),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] lt, input logic [7:0] x,
                                input logic [3:0] g, input logic [3:0] a, input logic p,
                                input logic [7:0] xo, input logic [6:0] yo, input logic [2:0] co,
                                input logic b);
        vec_t v;
        v.req = rq; v.last = lt; v.x = x; v.grant = g; v.ack = a; v.plot = p;
        v.xo = xo; v.yo = yo; v.co = co; v.busy = b;
        return v;
    endfunction

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // drive one vector at the falling edge, compare all outputs 1 ns later
    task automatic run_vec(input string name, input vec_t v);
        @(negedge clock);
        req  = v.req;
        last = v.last;
        for (int i = 0; i < 4; i++) xv[i] = v.x;
        #1;
        check(name, {grant, ack, plot_out, x_out, y_out, colour_out, busy},
                    {v.grant, v.ack, v.plot, v.xo, v.yo, v.co, v.busy});
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b0;
        last  = 4'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    int p, n0, cnt1, plotted;
    logic [3:0] prev_g;
    bit done;
    int owners[$];
    int bursts[$];

    initial begin
        for (int i = 0; i < 4; i++) xv[i] = 8'd0;

        // reset held with all requesters active
        for (int k = 0; k < 5; k++)
            run_vec($sformatf("reset_c%0d", k), mk(4'b1111, 4'b0000, 8'd0, 4'b0, 4'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0));
        @(negedge clock);
        reset = 1'b1;
        req   = 4'b0;

        // single owner, then pointer-driven picks
        tbl[0]  = mk(4'b0100, 4'b0000, 8'd10, 4'b0000, 4'b0000, 1'b0, 8'd0,  7'd0, 3'd0, 1'b0);
        tbl[1]  = mk(4'b0100, 4'b0000, 8'd10, 4'b0100, 4'b0100, 1'b0, 8'd0,  7'd0, 3'd0, 1'b1);
        tbl[2]  = mk(4'b0100, 4'b0000, 8'd11, 4'b0100, 4'b0100, 1'b1, 8'd10, 7'd5, 3'd2, 1'b1);
        tbl[3]  = mk(4'b0100, 4'b0100, 8'd12, 4'b0100, 4'b0100, 1'b1, 8'd11, 7'd5, 3'd2, 1'b1);
        tbl[4]  = mk(4'b0000, 4'b0000, 8'd0,  4'b0000, 4'b0000, 1'b1, 8'd12, 7'd5, 3'd2, 1'b1);
        tbl[5]  = mk(4'b0000, 4'b0000, 8'd0,  4'b0000, 4'b0000, 1'b0, 8'd12, 7'd5, 3'd2, 1'b0);
        tbl[6]  = mk(4'b1100, 4'b1100, 8'd20, 4'b0000, 4'b0000, 1'b0, 8'd12, 7'd5, 3'd2, 1'b0);
        tbl[7]  = mk(4'b1100, 4'b1100, 8'd20, 4'b1000, 4'b1000, 1'b0, 8'd12, 7'd5, 3'd2, 1'b1);
        tbl[8]  = mk(4'b0101, 4'b0101, 8'd21, 4'b0000, 4'b0000, 1'b1, 8'd20, 7'd6, 3'd3, 1'b1);
        tbl[9]  = mk(4'b0101, 4'b0101, 8'd21, 4'b0000, 4'b0000, 1'b0, 8'd20, 7'd6, 3'd3, 1'b0);
        tbl[10] = mk(4'b0101, 4'b0101, 8'd21, 4'b0001, 4'b0001, 1'b0, 8'd20, 7'd6, 3'd3, 1'b1);
        tbl[11] = mk(4'b0100, 4'b0100, 8'd22, 4'b0000, 4'b0000, 1'b1, 8'd21, 7'd3, 3'd0, 1'b1);
        tbl[12] = mk(4'b0100, 4'b0100, 8'd22, 4'b0000, 4'b0000, 1'b0, 8'd21, 7'd3, 3'd0, 1'b0);
        tbl[13] = mk(4'b0100, 4'b0100, 8'd22, 4'b0100, 4'b0100, 1'b0, 8'd21, 7'd3, 3'd0, 1'b1);
        tbl[14] = mk(4'b0000, 4'b0000, 8'd0,  4'b0000, 4'b0000, 1'b1, 8'd22, 7'd5, 3'd2, 1'b1);
        tbl[15] = mk(4'b0000, 4'b0000, 8'd0,  4'b0000, 4'b0000, 1'b0, 8'd22, 7'd5, 3'd2, 1'b0);
        for (int k = 0; k < 16; k++) run_vec($sformatf("tbl_row%0d", k), tbl[k]);

        // stall: one low cycle keeps the grant, two low cycles release it
        do_reset();
        run_vec("stall_c0", mk(4'b0100, 4'b0, 8'd50, 4'b0000, 4'b0000, 1'b0, 8'd0,  7'd0, 3'd0, 1'b0));
        run_vec("stall_c1", mk(4'b0100, 4'b0, 8'd50, 4'b0100, 4'b0100, 1'b0, 8'd0,  7'd0, 3'd0, 1'b1));
        run_vec("stall_c2", mk(4'b0000, 4'b0, 8'd50, 4'b0100, 4'b0000, 1'b1, 8'd50, 7'd5, 3'd2, 1'b1));
        run_vec("stall_c3", mk(4'b0100, 4'b0, 8'd51, 4'b0100, 4'b0100, 1'b0, 8'd50, 7'd5, 3'd2, 1'b1));
        run_vec("stall_c4", mk(4'b0000, 4'b0, 8'd51, 4'b0100, 4'b0000, 1'b1, 8'd51, 7'd5, 3'd2, 1'b1));
        run_vec("stall_c5", mk(4'b0000, 4'b0, 8'd51, 4'b0100, 4'b0000, 1'b0, 8'd51, 7'd5, 3'd2, 1'b1));
        run_vec("stall_c6", mk(4'b0000, 4'b0, 8'd51, 4'b0000, 4'b0000, 1'b0, 8'd51, 7'd5, 3'd2, 1'b1));
        run_vec("stall_c7", mk(4'b0000, 4'b0, 8'd51, 4'b0000, 4'b0000, 1'b0, 8'd51, 7'd5, 3'd2, 1'b0));

        // reset in the middle of a burst: nothing is written after the reset edge
        do_reset();
        run_vec("rstmid_c0", mk(4'b0100, 4'b0, 8'd1, 4'b0000, 4'b0000, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0));
        run_vec("rstmid_c1", mk(4'b0100, 4'b0, 8'd1, 4'b0100, 4'b0100, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1));
        run_vec("rstmid_c2", mk(4'b0100, 4'b0, 8'd2, 4'b0100, 4'b0100, 1'b1, 8'd1, 7'd5, 3'd2, 1'b1));
        @(negedge clock);
        reset = 1'b0;
        run_vec("rstmid_c4", mk(4'b0100, 4'b0, 8'd3, 4'b0000, 4'b0000, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0));
        reset = 1'b1;

        // round-robin over requesters 0,1,3 with single-pixel objects
        do_reset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clock);
            req  = 4'b1011;
            last = 4'b1011;
            #1;
            check($sformatf("rr_c%0d", c), grant, (c % 3 == 1) ? (4'b0001 << rr_order[c / 3]) : 4'b0000);
        end

        // priority: pointer moved to 2, then requesters 0 and 2 compete
        do_reset();
        run_vec("pri_c0", mk(4'b0010, 4'b0010, 8'd1, 4'b0000, 4'b0000, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0));
        run_vec("pri_c1", mk(4'b0010, 4'b0010, 8'd1, 4'b0010, 4'b0010, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1));
        run_vec("pri_c2", mk(4'b0101, 4'b0000, 8'd7, 4'b0000, 4'b0000, 1'b1, 8'd1, 7'd4, 3'd1, 1'b1));
        run_vec("pri_c3", mk(4'b0101, 4'b0000, 8'd7, 4'b0000, 4'b0000, 1'b0, 8'd1, 7'd4, 3'd1, 1'b0));
        run_vec("pri_c4", mk(4'b0101, 4'b0000, 8'd7, EXP_PRI, EXP_PRI, 1'b0, 8'd1, 7'd4, 3'd1, 1'b1));

        // burst limit: requester 1 streams 40 pixels, requester 0 has 3 single-pixel objects
        do_reset();
        p = 0; n0 = 0; cnt1 = 0; plotted = 0; prev_g = 4'b0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clock);
            req   = {2'b00, (p < 40), (n0 < 3)};
            last  = {2'b00, (p == 39), 1'b1};
            xv[0] = 8'd200;
            xv[1] = 8'(p);
            xv[2] = 8'd0;
            xv[3] = 8'd0;
            #1;
            if (grant != 4'b0 && prev_g == 4'b0) owners.push_back(idx_of(grant));
            if (ack[1]) begin
                cnt1++;
                p++;
            end
            if (ack[0]) n0++;
            if (grant == 4'b0 && prev_g[1]) begin
                bursts.push_back(cnt1);
                cnt1 = 0;
            end
            if (plot_out && y_out == 7'd4) begin
                check($sformatf("burst_px%0d", plotted), x_out, plotted);
                plotted++;
            end
            prev_g = grant;
            done   = (plotted == 40) && (bursts.size() == 3);
        end
        check("burst_done", done, 1);
        check("burst_owner_count", owners.size(), 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("burst_owner%0d", k), (k < owners.size()) ? owners[k] : 99, burst_order[k]);
        for (int k = 0; k < 3; k++)
            check($sformatf("burst_len%0d", k), (k < bursts.size()) ? bursts[k] : 99, burst_len[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
